// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM. It sequences the shared-ALU datapath, stalls on
// mem_ready, times out hung bus accesses, halts on system/illegal opcodes and counts retires.
module riscv_multicycle_ctrl #(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic [3:0]       nzcv,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             PCSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [2:0]       ImmSrc,
  output logic [4:0]       ALUControl,
  output logic [3:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_BRANCH   = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_SUB   = 5'b00001;
  localparam logic [4:0] ALU_SLL   = 5'b00010;
  localparam logic [4:0] ALU_SLT   = 5'b00011;
  localparam logic [4:0] ALU_SLTU  = 5'b00100;
  localparam logic [4:0] ALU_XOR   = 5'b00101;
  localparam logic [4:0] ALU_SRL   = 5'b00110;
  localparam logic [4:0] ALU_SRA   = 5'b00111;
  localparam logic [4:0] ALU_OR    = 5'b01000;
  localparam logic [4:0] ALU_AND   = 5'b01001;
  localparam logic [4:0] ALU_PASSB = 5'b01010;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // The wait counter only ever reaches WAIT_MAX-1 before a timeout fires.
  localparam int unsigned        WAIT_W    = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WAIT_W-1:0]  r_wait;
  logic [CNT_W-1:0]   r_instret;
  logic               r_halted;
  logic               r_illegal;
  logic               r_bus_err;

  logic       w_mem_req, w_mem_we, w_ir_write, w_pc_write, w_reg_write;
  logic       w_set_illegal, w_timeout, w_retire, w_wait_inc, w_wait_expired;
  logic       w_br_taken, w_br_bad;
  logic [4:0] w_exec_alu;

  assign w_wait_expired = (WAIT_MAX != 0) && (r_wait == WAIT_LAST);

  // Branch condition from the SUB flags {N,Z,C,V}; C=1 means no borrow.
  always_comb begin
    w_br_taken = 1'b0;
    w_br_bad   = 1'b0;
    case (funct3)
      3'b000:  w_br_taken = nzcv[2];
      3'b001:  w_br_taken = ~nzcv[2];
      3'b100:  w_br_taken = nzcv[3] ^ nzcv[0];
      3'b101:  w_br_taken = ~(nzcv[3] ^ nzcv[0]);
      3'b110:  w_br_taken = ~nzcv[1];
      3'b111:  w_br_taken = nzcv[1];
      default: w_br_bad   = 1'b1;
    endcase
  end

  always_comb begin
    w_exec_alu = ALU_ADD;
    case (funct3)
      3'b000:  w_exec_alu = (r_state == S_EXEC_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  w_exec_alu = ALU_SLL;
      3'b010:  w_exec_alu = ALU_SLT;
      3'b011:  w_exec_alu = ALU_SLTU;
      3'b100:  w_exec_alu = ALU_XOR;
      3'b101:  w_exec_alu = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  w_exec_alu = ALU_OR;
      default: w_exec_alu = ALU_AND;
    endcase
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next        = r_state;
    w_mem_req     = 1'b0;
    w_mem_we      = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_reg_write   = 1'b0;
    AdrSrc        = 1'b0;
    PCSrc         = 1'b0;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ResultSrc     = 2'b00;
    ALUControl    = ALU_ADD;
    ImmSrc        = (opcode == OP_BRANCH) ? IMM_B : (opcode == OP_JAL) ? IMM_J : IMM_I;
    w_set_illegal = 1'b0;
    w_timeout     = 1'b0;
    w_retire      = 1'b0;
    w_wait_inc    = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        ALUSrcB   = 2'b10;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          PCSrc      = 1'b1;
          w_next     = S_DECODE;
        end else if (w_wait_expired) begin
          w_timeout = 1'b1;
          w_next    = S_HALT;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXEC_R;
          OP_I:              w_next = S_EXEC_I;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
          OP_SYSTEM:         w_next = S_HALT;
          default: begin
            w_set_illegal = 1'b1;
            w_next        = S_HALT;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == OP_LOAD) ? IMM_I : IMM_S;
        w_next  = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD, S_MEMWRITE: begin
        w_mem_req = 1'b1;
        w_mem_we  = (r_state == S_MEMWRITE);
        AdrSrc    = 1'b1;
        if (mem_ready) begin
          w_next = (r_state == S_MEMREAD) ? S_MEMWB : S_FETCH;
        end else if (w_wait_expired) begin
          w_timeout = 1'b1;
          w_next    = S_HALT;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_MEMWB: begin
        w_reg_write = 1'b1;
        ResultSrc   = 2'b01;
        w_next      = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = (r_state == S_EXEC_I) ? 2'b01 : 2'b00;
        ALUControl = w_exec_alu;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        w_reg_write = 1'b1;
        ResultSrc   = 2'b11;
        w_pc_write  = 1'b1;
        w_next      = S_FETCH;
      end
      S_JALR: begin
        ALUSrcA     = 2'b10;
        ALUSrcB     = 2'b01;
        w_reg_write = 1'b1;
        ResultSrc   = 2'b11;
        w_pc_write  = 1'b1;
        PCSrc       = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        if (w_br_bad) begin
          w_set_illegal = 1'b1;
          w_next        = S_HALT;
        end else begin
          w_pc_write = w_br_taken;
          w_next     = S_FETCH;
        end
      end
      S_LUI: begin
        ALUSrcB     = 2'b01;
        ImmSrc      = IMM_U;
        ALUControl  = ALU_PASSB;
        w_reg_write = 1'b1;
        ResultSrc   = 2'b10;
        w_next      = S_FETCH;
      end
      S_AUIPC: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b01;
        ImmSrc      = IMM_U;
        w_reg_write = 1'b1;
        ResultSrc   = 2'b10;
        w_next      = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_HALT;
    endcase

    // Only completion states can retire; FETCH and MEMREAD never do.
    if (w_next == S_FETCH && r_state != S_FETCH && r_state != S_MEMREAD)
      w_retire = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_instret <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait <= '0;
      else if (w_wait_inc)
        r_wait <= r_wait + 1'b1;
      if (w_retire)
        r_instret <= r_instret + 1'b1;
      if (w_next == S_HALT)
        r_halted <= 1'b1;
      if (w_set_illegal)
        r_illegal <= 1'b1;
      if (w_timeout)
        r_bus_err <= 1'b1;
    end
  end

  // The reset state is FETCH, so strobes are masked while rst is held.
  assign mem_req  = w_mem_req   & ~rst;
  assign mem_we   = w_mem_we    & ~rst;
  assign IRWrite  = w_ir_write  & ~rst;
  assign PCWrite  = w_pc_write  & ~rst;
  assign RegWrite = w_reg_write & ~rst;

  assign state   = r_state;
  assign instret = r_instret;
  assign halted  = r_halted;
  assign illegal = r_illegal;
  assign bus_err = r_bus_err;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: cycle-by-cycle control vectors per instruction class,
// plus bus timeout (WAIT_MAX=4 instance), halts, and reset abort.
module tb_riscv_multicycle_ctrl;

  localparam logic [4:0] A_ADD = 5'b00000, A_SUB = 5'b00001, A_SRL = 5'b00110, A_SRA = 5'b00111;
  localparam logic [4:0] A_SLTU = 5'b00100, A_AND = 5'b01001, A_PASSB = 5'b01010;
  // strobe groups: {mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, PCSrc}
  localparam logic [6:0] S_NONE = 7'b0000000, S_FETCH = 7'b1001101, S_RD = 7'b1010000;
  localparam logic [6:0] S_WR = 7'b1110000, S_RW = 7'b0000010, S_PCW = 7'b0000100;
  localparam logic [6:0] S_JAL = 7'b0000110, S_JALR = 7'b0000111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic [3:0] nzcv = 4'd0;
  logic       mem_ready = 1'b0;

  logic mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, PCSrc, halted, illegal, bus_err;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSrc;
  logic [4:0] ALUControl;
  logic [3:0] state;
  logic [31:0] instret;

  logic mem_req_t, mem_we_t, AdrSrc_t, IRWrite_t, PCWrite_t, RegWrite_t, PCSrc_t;
  logic halted_t, illegal_t, bus_err_t;
  logic [1:0] ALUSrcA_t, ALUSrcB_t, ResultSrc_t;
  logic [2:0] ImmSrc_t;
  logic [4:0] ALUControl_t;
  logic [3:0] state_t;
  logic [31:0] instret_t;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_instret = 32'd0;

  riscv_multicycle_ctrl #(.WAIT_MAX(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .nzcv(nzcv),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .state(state), .halted(halted), .illegal(illegal),
    .bus_err(bus_err), .instret(instret)
  );

  riscv_multicycle_ctrl #(.WAIT_MAX(4), .CNT_W(32)) dut_t (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .nzcv(nzcv),
    .mem_ready(mem_ready), .mem_req(mem_req_t), .mem_we(mem_we_t), .AdrSrc(AdrSrc_t),
    .IRWrite(IRWrite_t), .PCWrite(PCWrite_t), .RegWrite(RegWrite_t), .PCSrc(PCSrc_t),
    .ALUSrcA(ALUSrcA_t), .ALUSrcB(ALUSrcB_t), .ResultSrc(ResultSrc_t), .ImmSrc(ImmSrc_t),
    .ALUControl(ALUControl_t), .state(state_t), .halted(halted_t), .illegal(illegal_t),
    .bus_err(bus_err_t), .instret(instret_t)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [24:0] pk(input logic [3:0] st, input logic [6:0] stb,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] rs, input logic [2:0] im,
                                     input logic [4:0] alu);
    return {st, stb, sa, sb, rs, im, alu};
  endfunction

  function automatic logic [24:0] ctl();
    return {state, mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, PCSrc,
            ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    nzcv = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    exp_instret = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (state !== 4'd0 || {mem_req, mem_we, IRWrite, PCWrite, RegWrite} !== 5'b0 ||
        instret !== 32'd0 || {halted, illegal, bus_err} !== 3'b0)
      begin n_fail++; $display("FAIL reset_hold got state=%0d stb=%b instret=%0d flags=%b exp state=0 stb=0 instret=0 flags=0",
                               state, {mem_req, mem_we, IRWrite, PCWrite, RegWrite}, instret, {halted, illegal, bus_err}); end
    n_checks++;
    if (state_t !== 4'd0 || mem_req_t !== 1'b0 || {halted_t, illegal_t, bus_err_t} !== 3'b0)
      begin n_fail++; $display("FAIL reset_hold_t got state=%0d mem_req=%b exp 0/0", state_t, mem_req_t); end
    rst = 1'b0;
    exp_instret = 32'd0;
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || state !== 4'd0)
      begin n_fail++; $display("FAIL reset_first_req got mem_req=%b state=%0d exp 1/0", mem_req, state); end
  endtask

  task automatic test_add();
    logic [24:0] e[$];
    opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
    e.push_back(pk(4'd0, S_FETCH, 2'b00, 2'b10, 2'b00, 3'b000, A_ADD));
    e.push_back(pk(4'd1, S_NONE,  2'b01, 2'b01, 2'b00, 3'b000, A_ADD));
    e.push_back(pk(4'd6, S_NONE,  2'b10, 2'b00, 2'b00, 3'b000, A_ADD));
    e.push_back(pk(4'd8, S_RW,    2'b00, 2'b00, 2'b00, 3'b000, A_ADD));
    for (int c = 0; c < e.size(); c++) begin
      #1;
      n_checks++;
      if (ctl() !== e[c]) begin n_fail++; $display("FAIL add_cyc%0d got=%h exp=%h", c + 1, ctl(), e[c]); end
      tick();
    end
    exp_instret++;
    #1;
    n_checks++;
    if (instret !== exp_instret || state !== 4'd0)
      begin n_fail++; $display("FAIL add_retire got instret=%0d state=%0d exp %0d/0", instret, state, exp_instret); end
  endtask

  task automatic test_load_wait();
    logic [24:0] e[$];
    logic        rdy[$];
    opcode = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    e.push_back(pk(4'd0, S_FETCH, 2'b00, 2'b10, 2'b00, 3'b000, A_ADD)); rdy.push_back(1'b1);
    e.push_back(pk(4'd1, S_NONE,  2'b01, 2'b01, 2'b00, 3'b000, A_ADD)); rdy.push_back(1'b0);
    e.push_back(pk(4'd2, S_NONE,  2'b10, 2'b01, 2'b00, 3'b000, A_ADD)); rdy.push_back(1'b0);
    for (int w = 0; w < 3; w++) begin
      e.push_back(pk(4'd3, S_RD, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD)); rdy.push_back(1'b0);
    end
    e.push_back(pk(4'd3, S_RD, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD)); rdy.push_back(1'b1);
    e.push_back(pk(4'd4, S_RW, 2'b00, 2'b00, 2'b01, 3'b000, A_ADD)); rdy.push_back(1'b0);
    for (int c = 0; c < e.size(); c++) begin
      mem_ready = rdy[c];
      #1;
      n_checks++;
      if (ctl() !== e[c]) begin n_fail++; $display("FAIL lw_cyc%0d got=%h exp=%h", c + 1, ctl(), e[c]); end
      tick();
    end
    exp_instret++;
    #1;
    n_checks++;
    if (instret !== exp_instret || state !== 4'd0 || bus_err !== 1'b0)
      begin n_fail++; $display("FAIL lw_retire got instret=%0d state=%0d bus_err=%b exp %0d/0/0", instret, state, bus_err, exp_instret); end
    // WAIT_MAX=4 instance saw 3 wait cycles then ready exactly at its limit: ready must win
    n_checks++;
    if (state_t !== 4'd0 || bus_err_t !== 1'b0 || halted_t !== 1'b0)
      begin n_fail++; $display("FAIL lw_ready_wins got state=%0d bus_err=%b halted=%b exp 0/0/0", state_t, bus_err_t, halted_t); end
  endtask

  task automatic test_store();
    logic [24:0] e[$];
    opcode = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
    e.push_back(pk(4'd0, S_FETCH, 2'b00, 2'b10, 2'b00, 3'b000, A_ADD));
    e.push_back(pk(4'd1, S_NONE,  2'b01, 2'b01, 2'b00, 3'b000, A_ADD));
    e.push_back(pk(4'd2, S_NONE,  2'b10, 2'b01, 2'b00, 3'b001, A_ADD));
    e.push_back(pk(4'd5, S_WR,    2'b00, 2'b00, 2'b00, 3'b000, A_ADD));
    for (int c = 0; c < e.size(); c++) begin
      #1;
      n_checks++;
      if (ctl() !== e[c]) begin n_fail++; $display("FAIL sw_cyc%0d got=%h exp=%h", c + 1, ctl(), e[c]); end
      tick();
    end
    exp_instret++;
    #1;
    n_checks++;
    if (instret !== exp_instret || state !== 4'd0)
      begin n_fail++; $display("FAIL sw_retire got instret=%0d state=%0d exp %0d/0", instret, state, exp_instret); end
  endtask

  task automatic test_exec();
    logic [6:0] t_op[6]  = '{7'b0110011, 7'b0010011, 7'b0010011, 7'b0110011, 7'b0010011, 7'b0110011};
    logic [2:0] t_f3[6]  = '{3'b000, 3'b101, 3'b000, 3'b101, 3'b111, 3'b011};
    logic       t_f7[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [4:0] t_alu[6] = '{A_SUB, A_SRA, A_ADD, A_SRL, A_AND, A_SLTU};
    for (int k = 0; k < 6; k++) begin
      logic [24:0] e[$];
      logic        is_i;
      is_i = (t_op[k] == 7'b0010011);
      opcode = t_op[k]; funct3 = t_f3[k]; funct7b5 = t_f7[k]; mem_ready = 1'b1;
      e.push_back(pk(4'd0, S_FETCH, 2'b00, 2'b10, 2'b00, 3'b000, A_ADD));
      e.push_back(pk(4'd1, S_NONE,  2'b01, 2'b01, 2'b00, 3'b000, A_ADD));
      e.push_back(pk(is_i ? 4'd7 : 4'd6, S_NONE, 2'b10, is_i ? 2'b01 : 2'b00, 2'b00, 3'b000, t_alu[k]));
      e.push_back(pk(4'd8, S_RW, 2'b00, 2'b00, 2'b00, 3'b000, A_ADD));
      for (int c = 0; c < e.size(); c++) begin
        #1;
        n_checks++;
        if (ctl() !== e[c]) begin n_fail++; $display("FAIL exec%0d_cyc%0d got=%h exp=%h", k, c + 1, ctl(), e[c]); end
        tick();
      end
      exp_instret++;
    end
    #1;
    n_checks++;
    if (instret !== exp_instret)
      begin n_fail++; $display("FAIL exec_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_branch();
    logic [2:0] t_f3[5]   = '{3'b000, 3'b000, 3'b110, 3'b110, 3'b101};
    logic [3:0] t_nzcv[5] = '{4'b0100, 4'b0000, 4'b0000, 4'b0010, 4'b1001};
    logic       t_tk[5]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      logic [24:0] e[$];
      opcode = 7'b1100011; funct3 = t_f3[k]; funct7b5 = 1'b0; nzcv = t_nzcv[k]; mem_ready = 1'b1;
      e.push_back(pk(4'd0, S_FETCH, 2'b00, 2'b10, 2'b00, 3'b010, A_ADD));
      e.push_back(pk(4'd1, S_NONE,  2'b01, 2'b01, 2'b00, 3'b010, A_ADD));
      e.push_back(pk(4'd11, t_tk[k] ? S_PCW : S_NONE, 2'b10, 2'b00, 2'b00, 3'b010, A_SUB));
      for (int c = 0; c < e.size(); c++) begin
        #1;
        n_checks++;
        if (ctl() !== e[c]) begin n_fail++; $display("FAIL br%0d_cyc%0d got=%h exp=%h", k, c + 1, ctl(), e[c]); end
        tick();
      end
      exp_instret++;
      #1;
      n_checks++;
      if (instret !== exp_instret || state !== 4'd0)
        begin n_fail++; $display("FAIL br%0d_retire got instret=%0d state=%0d exp %0d/0", k, instret, state, exp_instret); end
    end
    nzcv = 4'd0;
  endtask

  task automatic test_jumps();
    logic [6:0]  t_op[4] = '{7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111};
    logic [24:0] t_ex[4];
    logic [2:0]  t_im[4] = '{3'b000, 3'b011, 3'b000, 3'b000};
    t_ex[0] = pk(4'd10, S_JALR, 2'b10, 2'b01, 2'b11, 3'b000, A_ADD);
    t_ex[1] = pk(4'd9,  S_JAL,  2'b00, 2'b00, 2'b11, 3'b011, A_ADD);
    t_ex[2] = pk(4'd12, S_RW,   2'b00, 2'b01, 2'b10, 3'b100, A_PASSB);
    t_ex[3] = pk(4'd13, S_RW,   2'b01, 2'b01, 2'b10, 3'b100, A_ADD);
    for (int k = 0; k < 4; k++) begin
      logic [24:0] e[$];
      opcode = t_op[k]; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
      e.push_back(pk(4'd0, S_FETCH, 2'b00, 2'b10, 2'b00, t_im[k], A_ADD));
      e.push_back(pk(4'd1, S_NONE,  2'b01, 2'b01, 2'b00, t_im[k], A_ADD));
      e.push_back(t_ex[k]);
      for (int c = 0; c < e.size(); c++) begin
        #1;
        n_checks++;
        if (ctl() !== e[c]) begin n_fail++; $display("FAIL jump%0d_cyc%0d got=%h exp=%h", k, c + 1, ctl(), e[c]); end
        tick();
      end
      exp_instret++;
    end
    #1;
    n_checks++;
    if (instret !== exp_instret)
      begin n_fail++; $display("FAIL jump_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (state_t !== 4'd0 || mem_req_t !== 1'b1)
        begin n_fail++; $display("FAIL tmo_wait%0d got state=%0d mem_req=%b exp 0/1", c + 1, state_t, mem_req_t); end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (state_t !== 4'd15 || mem_req_t !== 1'b0 || {halted_t, illegal_t, bus_err_t} !== 3'b101)
        begin n_fail++; $display("FAIL tmo_halt%0d got state=%0d mem_req=%b flags=%b exp 15/0/101",
                                 c, state_t, mem_req_t, {halted_t, illegal_t, bus_err_t}); end
      tick();
    end
    n_checks++;
    if (state !== 4'd0 || bus_err !== 1'b0)
      begin n_fail++; $display("FAIL tmo_wait16 got state=%0d bus_err=%b exp 0/0", state, bus_err); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (state_t !== 4'd0 || {halted_t, illegal_t, bus_err_t} !== 3'b000)
      begin n_fail++; $display("FAIL tmo_recover got state=%0d flags=%b exp 0/000", state_t, {halted_t, illegal_t, bus_err_t}); end
    do_reset();
  endtask

  task automatic test_halt();
    logic [6:0] t_op[3]  = '{7'b1111111, 7'b1110011, 7'b1100011};
    logic [2:0] t_f3[3]  = '{3'b000, 3'b000, 3'b010};
    int         t_cyc[3] = '{2, 2, 3};
    logic       t_ill[3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      opcode = t_op[k]; funct3 = t_f3[k]; funct7b5 = 1'b0; mem_ready = 1'b1;
      for (int c = 0; c < t_cyc[k]; c++) tick();
      for (int c = 0; c < 2; c++) begin
        #1;
        n_checks++;
        if (state !== 4'd15 || ctl()[20:14] !== S_NONE || halted !== 1'b1 || illegal !== t_ill[k] ||
            bus_err !== 1'b0 || instret !== exp_instret)
          begin n_fail++; $display("FAIL halt%0d_c%0d got state=%0d stb=%b h=%b i=%b b=%b instret=%0d exp 15/0/1/%b/0/%0d",
                                   k, c, state, ctl()[20:14], halted, illegal, bus_err, instret, t_ill[k], exp_instret); end
        tick();
      end
    end
    do_reset();
  endtask

  task automatic test_abort();
    do_reset();
    opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (state !== 4'd8 || RegWrite !== 1'b1)
      begin n_fail++; $display("FAIL abort_pre got state=%0d RegWrite=%b exp 8/1", state, RegWrite); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (state !== 4'd0 || RegWrite !== 1'b0)
      begin n_fail++; $display("FAIL abort_async got state=%0d RegWrite=%b exp 0/0", state, RegWrite); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (instret !== 32'd0 || state !== 4'd0)
      begin n_fail++; $display("FAIL abort_no_retire got instret=%0d state=%0d exp 0/0", instret, state); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_store();
    test_exec();
    test_branch();
    test_jumps();
    test_timeout();
    test_halt();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Multi-cycle control unit for the RV32I core. It replaces the single-cycle controller with an FSM that drives the shared-ALU datapath over several cycles per instruction. It stalls on a memory ready handshake, times out on a hung bus, halts on illegal or system opcodes, and counts retired instructions. It sits between the instruction/data memory port and the multi-cycle datapath.

## Interface
- WAIT_MAX, 16: maximum consecutive cycles with mem_ready low in one memory state; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  latched Instr[6:0].
- funct3  in  3  latched Instr[14:12].
- funct7b5  in  1  latched Instr[30].
- nzcv  in  4  ALU flags of the current cycle. C = 1 means no borrow on SUB.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req / mem_we  out  1 / 1  memory request and write qualifier.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite, PCWrite, RegWrite  out  1 each  register enables.
- PCSrc  out  1  next-PC select: 0 = ALUOut, 1 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = ReadData, 10 = ALUResult, 11 = PC.
- ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- ALUControl  out  5  ADD 00000, SUB 00001, SLL 00010, SLT 00011, SLTU 00100, XOR 00101, SRL 00110, SRA 00111, OR 01000, AND 01001, PASSB 01010.
- state  out  4  current state, for debug.
- halted, illegal, bus_err  out  1 each  sticky status flags.
- instret  out  CNT_W  count of retired instructions.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXEC_R 6, EXEC_I 7, ALUWB 8, JAL 9, JALR 10, BRANCH 11, LUI 12, AUIPC 13, HALT 15.
- FETCH:
  - Drives mem_req=1, AdrSrc=0, ALU = PC + 4 (SrcA 00, SrcB 10, ADD).
  - On mem_ready: IRWrite=1, PCWrite=1 with PCSrc=1, go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - ALU = OldPC + imm, with ImmSrc = B for branches, J for JAL, I otherwise.
  - Dispatch on opcode:
    - 0000011 / 0100011 → MEMADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1101111 → JAL
    - 1100111 → JALR
    - 1100011 → BRANCH
    - 0110111 → LUI
    - 0010111 → AUIPC
    - 1110011 → HALT (halted=1)
    - any other opcode → HALT (halted=1, illegal=1)
- MEMADR: ALU = rs1 + imm, ImmSrc I for loads, S for stores. Go to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: mem_req=1, AdrSrc=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: RegWrite=1, ResultSrc=01, then FETCH.
- MEMWRITE: mem_req=1, mem_we=1, AdrSrc=1. Wait for mem_ready, then FETCH.
- EXEC_R / EXEC_I: SrcA=rs1, SrcB = rs2 or imm (I).
  - funct3 → op: 000 ADD (SUB when EXEC_R and funct7b5=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA when funct7b5=1), 110 OR, 111 AND.
  - Next state: ALUWB.
- ALUWB: RegWrite=1, ResultSrc=00, then FETCH.
- JAL: RegWrite=1, ResultSrc=11; PCWrite=1, PCSrc=0; then FETCH.
- JALR: ALU = rs1 + imm; RegWrite=1, ResultSrc=11; PCWrite=1, PCSrc=1; then FETCH.
- BRANCH: ALU = rs1 − rs2 (SUB).
  - Taken condition by funct3: 000 Z, 001 !Z, 100 N^V, 101 !(N^V), 110 !C, 111 C. Funct3 010/011 → HALT with illegal=1.
  - If taken: PCWrite=1, PCSrc=0. Then FETCH.
- LUI: SrcB=imm (U), PASSB, RegWrite=1, ResultSrc=10, then FETCH.
- AUIPC: SrcA=OldPC, SrcB=imm (U), ADD, RegWrite=1, ResultSrc=10, then FETCH.
- HALT: all strobes 0. Exit only through rst.
- Wait counter:
  - Clears on every state change.
  - Increments each cycle in FETCH, MEMREAD or MEMWRITE while mem_ready=0.
  - If WAIT_MAX≠0 and the counter reaches WAIT_MAX−1 with mem_ready still 0: go to HALT and set bus_err=1.
  - mem_ready in that same cycle wins; no timeout.
- instret increments on every transition from MEMWB, MEMWRITE, ALUWB, JAL, JALR, BRANCH, LUI or AUIPC into FETCH. It wraps modulo 2^CNT_W.
- Outputs not listed for a state are 0. ALUControl is ADD; ImmSrc holds the DECODE value.

## Timing
- Reset:
  - While rst=1: state=FETCH, counter=0, instret=0, halted, illegal and bus_err = 0, and every strobe (mem_req, mem_we, IRWrite, PCWrite, RegWrite) is forced to 0.
  - The first mem_req comes in the first cycle after rst falls.
  - rst asserted mid-instruction aborts it immediately. No retire.
- All outputs except state, instret and the flags are combinational from state, opcode, funct3, funct7b5, nzcv and mem_ready. Registers update on the rising clk edge.
- Cycles per instruction with zero wait states (mem_ready=1 on first request):
  - load 5
  - R/I-type 4
  - store 4
  - JAL, JALR, BRANCH, LUI, AUIPC 3
- Each wait cycle adds one cycle.

## Test plan
- Reset, then zero-wait ADD (0x002081B3) → FETCH→DECODE→EXEC_R→ALUWB; RegWrite in cycle 4; instret=1 at cycle 5.
- LW with mem_ready low for 3 cycles in MEMREAD, WAIT_MAX=16 → load takes 8 cycles; MEMWB RegWrite with ResultSrc=01; bus_err=0.
- FETCH with mem_ready held 0, WAIT_MAX=4 → HALT after 4 cycles, bus_err=1, no further mem_req; rst recovers with state=0.
- BEQ with nzcv Z=1 vs Z=0; BLTU with C=0 → PCWrite=1 with PCSrc=0 only when taken; 3 cycles each; instret increments either way.
- Opcode 0x7F and ECALL 0x00000073 → HALT; illegal=1 only for 0x7F; halted=1 for both; instret unchanged.
- JALR and SRAI (funct7b5=1) → JALR: RegWrite with ResultSrc=11 in the same cycle as PCWrite with PCSrc=1. SRAI: ALUControl=00111.
